// File: rtl/h_squeeze_reader.sv
// SHAKE256 squeeze reader: captures the Keccak rate block on perm_done and
// streams it out as WORD_W words, requesting further permutations as needed.
module h_squeeze_reader #(
    parameter int STATE_W = 1600,
    parameter int RATE_W  = 1088,
    parameter int WORD_W  = 64,
    parameter int LEN_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LEN_W-1:0]   out_len,
    input  logic               perm_done,
    input  logic [STATE_W-1:0] perm_state,
    output logic               perm_req,
    output logic [WORD_W-1:0]  word_out,
    output logic               word_valid,
    input  logic               word_ready,
    output logic               busy,
    output logic               done
);

    localparam int NWORDS = RATE_W / WORD_W;
    localparam int IDX_W  = $clog2(NWORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PERM,
        STREAM,
        REQ,
        FIN
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [RATE_W-1:0]  rate_buf;
    logic [IDX_W-1:0]   idx;
    logic [LEN_W-1:0]   remaining;
    logic               hs;
    logic               capture;
    logic               unused_hi;

    // Capacity bits never leave the sponge.
    assign unused_hi = ^perm_state[STATE_W-1:RATE_W];

    assign hs      = (state == STREAM) && word_ready;
    assign capture = (state == WAIT_PERM) && perm_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (out_len != '0) ? WAIT_PERM : FIN;
                end
            end
            WAIT_PERM: begin
                if (perm_done) begin
                    state_nx = STREAM;
                end
            end
            STREAM: begin
                // Session end wins over block end: no wasted permutation.
                if (hs) begin
                    if (remaining == LEN_W'(1)) begin
                        state_nx = FIN;
                    end else if (idx == LAST_IDX) begin
                        state_nx = REQ;
                    end
                end
            end
            REQ:     state_nx = WAIT_PERM;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rate_buf  <= '0;
            idx       <= '0;
            remaining <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                remaining <= out_len;
            end
            if (capture) begin
                rate_buf <= perm_state[RATE_W-1:0];
                idx      <= '0;
            end else if (hs) begin
                // Shift so the current word always sits in the LSBs.
                rate_buf <= rate_buf >> WORD_W;
                idx      <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                if (remaining != '0) begin
                    remaining <= remaining - 1'b1;
                end
            end
        end
    end

    assign word_valid = (state == STREAM);
    assign word_out   = word_valid ? rate_buf[WORD_W-1:0] : '0;
    assign perm_req   = (state == REQ);
    assign done       = (state == FIN);
    assign busy       = (state != IDLE);

endmodule
